// File: rtl/chip8_tone_gen.sv
// chip8_tone_gen: turns the sound-timer active level into enveloped square-wave samples
// delivered over valid/ready. Define CHIP8_TONE_RAMP_EN for the attack/release envelope.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | silent; phase=0, polarity=+ so each tone starts positive
// RAMP_UP   | envelope rising by STEP per tick (CHIP8_TONE_RAMP_EN only)
// ON        | envelope held at AMP
// RAMP_DOWN | envelope falling by STEP per tick (CHIP8_TONE_RAMP_EN only)
module chip8_tone_gen #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SAMPLE_HZ  = 48_000,
    parameter int TONE_HZ    = 440,
    parameter int AMP        = 16'sh2000,
    parameter int RAMP_STEPS = 64,
    parameter int W          = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sound_on,
    output logic [W-1:0] sample_data,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic         busy,
    output logic         overrun
);

    localparam int DIV_RAW  = CLK_HZ / SAMPLE_HZ;
    localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HALF_RAW = SAMPLE_HZ / (2 * TONE_HZ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int PH_W     = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF - 1);
    localparam logic [W-1:0]     AMP_V    = W'(AMP);

    // Elaboration-time guard against parameter sets that cannot produce a tone.
    if (AMP < 1 || RAMP_STEPS < 1 || DIV_RAW < 1) begin : g_bad_params
        $error("chip8_tone_gen: AMP, RAMP_STEPS and CLK_HZ/SAMPLE_HZ must be >= 1");
    end

`ifdef CHIP8_TONE_RAMP_EN
    localparam int STEP_RAW = AMP / RAMP_STEPS;
    localparam int STEP     = (STEP_RAW < 1) ? 1 : STEP_RAW;
    localparam logic [W:0]   STEP_WIDE = (W+1)'(STEP);
    localparam logic [W-1:0] STEP_V    = W'(STEP);

    typedef enum logic [1:0] {IDLE, RAMP_UP, ON, RAMP_DOWN} state_t;
`else
    typedef enum logic {IDLE, ON} state_t;
`endif

    state_t            state;
    state_t            state_n;
    logic [W-1:0]      env;
    logic [W-1:0]      env_n;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_n;
    logic              polarity;
    logic              polarity_n;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [W-1:0]      sample_n;

    assign tick = (div_cnt == DIV_LAST);
    assign busy = (state != IDLE);

`ifdef CHIP8_TONE_RAMP_EN
    logic [W:0]   env_sum;
    logic [W-1:0] env_up;
    logic [W-1:0] env_dn;

    // Saturating step helpers; env never exceeds AMP so the sum fits in W+1 bits.
    always_comb begin
        env_sum = {1'b0, env} + STEP_WIDE;
        env_up  = (env_sum > {1'b0, AMP_V}) ? AMP_V : env_sum[W-1:0];
        env_dn  = (env > STEP_V) ? (env - STEP_V) : '0;
    end

    always_comb begin
        state_n = state;
        env_n   = env;
        case (state)
            IDLE: begin
                if (sound_on) begin
                    env_n   = env_up;
                    state_n = (env_up == AMP_V) ? ON : RAMP_UP;
                end
            end
            RAMP_UP: begin
                // Release from a partial attack starts next tick; no step now.
                if (!sound_on) begin
                    state_n = RAMP_DOWN;
                end else begin
                    env_n = env_up;
                    if (env_up == AMP_V) state_n = ON;
                end
            end
            ON: begin
                if (!sound_on) begin
                    env_n   = env_dn;
                    state_n = (env_dn == '0) ? IDLE : RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                if (sound_on) begin
                    env_n   = env_up;
                    state_n = (env_up == AMP_V) ? ON : RAMP_UP;
                end else begin
                    env_n = env_dn;
                    if (env_dn == '0) state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                env_n   = '0;
            end
        endcase
    end
`else
    always_comb begin
        state_n = state;
        env_n   = env;
        case (state)
            IDLE: begin
                if (sound_on) begin
                    state_n = ON;
                    env_n   = AMP_V;
                end
            end
            ON: begin
                if (!sound_on) begin
                    state_n = IDLE;
                    env_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                env_n   = '0;
            end
        endcase
    end
`endif

    // Sample uses the updated env but the pre-toggle polarity of this tick.
    always_comb begin
        phase_n    = phase;
        polarity_n = polarity;
        if (state_n == IDLE) begin
            phase_n    = '0;
            polarity_n = 1'b0;
        end else if (phase == PH_LAST) begin
            phase_n    = '0;
            polarity_n = ~polarity;
        end else begin
            phase_n = phase + 1'b1;
        end

        if (state_n == IDLE) begin
            sample_n = '0;
        end else if (polarity) begin
            sample_n = '0 - env_n;
        end else begin
            sample_n = env_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (tick) begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            env      <= '0;
            phase    <= '0;
            polarity <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                env      <= env_n;
                phase    <= phase_n;
                polarity <= polarity_n;
            end
        end
    end

    // A tick that finds the previous sample still pending drops the new one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (tick) begin
            if (!sample_valid || sample_ready) begin
                sample_data  <= sample_n;
                sample_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

endmodule
